// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB control FSM of the 16-bit RISC core,
// with instruction/data memory handshakes, illegal-opcode detection and ack timeout.
module multicycle_control #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] instr_opcode,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    input  logic       alu_zero,
    output logic       imem_req,
    output logic       ir_load,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [1:0] alu_op,
    output logic [3:0] opcode_q,
    output logic       alu_src,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic       bus_err,
    output logic       halted,
    output logic [2:0] state_dbg
);
    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       opcode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic is_r, is_ld, is_st, is_beq, is_bne, is_jmp, is_halt, is_mem, is_br, legal, timeout;

    assign is_r      = opcode_q <= 4'd4;
    assign is_ld     = opcode_q == 4'b1000;
    assign is_st     = opcode_q == 4'b1001;
    assign is_beq    = opcode_q == 4'b1010;
    assign is_bne    = opcode_q == 4'b1011;
    assign is_jmp    = opcode_q == 4'b1100;
    assign is_halt   = opcode_q == 4'b1111;
    assign is_mem    = is_ld | is_st;
    assign is_br     = is_beq | is_bne;
    assign legal     = is_r | is_mem | is_br | is_jmp | is_halt;
    assign timeout   = cnt_q == CNT_W'(TIMEOUT - 1);
    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_RST;
            opcode_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
        end
    end

    // The counter only runs while waiting in FETCH/MEM, so any state change clears it.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        cnt_d      = '0;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_op     = 2'b10;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
                if (imem_ack) begin
                    opcode_d = instr_opcode;
                    state_d  = S_DECODE;
                end else if (timeout) state_d = S_ERROR;
                else cnt_d = cnt_q + 1'b1;
            end
            S_DECODE: begin
                pc_write = legal & ~is_halt;
                pc_src   = is_jmp ? 2'b10 : 2'b00;
                illegal  = ~legal;
                state_d  = is_halt ? S_HALT : (!legal || is_jmp) ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
                alu_op   = is_r ? 2'b00 : is_br ? 2'b01 : 2'b10;
                alu_src  = is_mem;
                pc_src   = is_br ? 2'b01 : 2'b00;
                pc_write = (is_beq & alu_zero) | (is_bne & ~alu_zero);
                state_d  = is_r ? S_WB : is_mem ? S_MEM : S_FETCH;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_st;
                if (dmem_ack) state_d = is_ld ? S_WB : S_FETCH;
                else if (timeout) state_d = S_ERROR;
                else cnt_d = cnt_q + 1'b1;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_ld;
                state_d    = S_FETCH;
            end
            S_HALT:  halted  = 1'b1;
            S_ERROR: bus_err = 1'b1;
            default: state_d = S_RST;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle vectors for multicycle_control, checking
// state, the packed output strobes and the latched opcode just before each rising edge.
module tb_multicycle_control;
    localparam logic [2:0] RST = 3'd0, FET = 3'd1, DEC = 3'd2, EXE = 3'd3,
                           MEM = 3'd4, WB = 3'd5, HLT = 3'd6, ERR = 3'd7;
    // Output word: {imem_req, ir_load, dmem_req, dmem_we, alu_op, alu_src, reg_write,
    //               mem_to_reg, pc_write, pc_src, illegal, bus_err, halted}
    localparam logic [14:0] IREQ = 15'h4000, IRL = 15'h2000, DREQ = 15'h1000, DWE = 15'h0800,
                            A10 = 15'h0400, A01 = 15'h0200, ASRC = 15'h0100, RW = 15'h0080,
                            M2R = 15'h0040, PCW = 15'h0020, PCJ = 15'h0010, PCB = 15'h0008,
                            ILL = 15'h0004, BERR = 15'h0002, HALT = 15'h0001;

    typedef struct packed {
        logic        rst_n;
        logic [3:0]  op;
        logic        ia, da, az;
        logic [2:0]  st;
        logic [14:0] outs;
        logic [3:0]  opq;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0, alu_zero = 1'b0;
    logic [3:0] instr_opcode = 4'h0;
    logic imem_req, ir_load, dmem_req, dmem_we, alu_src, reg_write, mem_to_reg, pc_write;
    logic illegal, bus_err, halted;
    logic [1:0] alu_op, pc_src;
    logic [3:0] opcode_q;
    logic [2:0] state_dbg;
    logic [14:0] outs;
    int total = 0, bad = 0;
    vec_t tbl[$];

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .instr_opcode(instr_opcode), .imem_ack(imem_ack),
        .dmem_ack(dmem_ack), .alu_zero(alu_zero), .imem_req(imem_req), .ir_load(ir_load),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_op(alu_op), .opcode_q(opcode_q),
        .alu_src(alu_src), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .pc_write(pc_write), .pc_src(pc_src), .illegal(illegal), .bus_err(bus_err),
        .halted(halted), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign outs = {imem_req, ir_load, dmem_req, dmem_we, alu_op, alu_src, reg_write,
                   mem_to_reg, pc_write, pc_src, illegal, bus_err, halted};

    task automatic add(input logic r, input logic [3:0] op, input logic ia, input logic da,
                       input logic az, input logic [2:0] st, input logic [14:0] o,
                       input logic [3:0] q);
        tbl.push_back({r, op, ia, da, az, st, o, q});
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge clk);
        rst_n = v.rst_n; instr_opcode = v.op; imem_ack = v.ia; dmem_ack = v.da; alu_zero = v.az;
        #2;
        total++;
        if (state_dbg !== v.st) begin
            bad++;
            $display("FAIL %s state got %0d want %0d", nm, state_dbg, v.st);
        end
        total++;
        if (outs !== v.outs) begin
            bad++;
            $display("FAIL %s outputs got %h want %h", nm, outs, v.outs);
        end
        total++;
        if (opcode_q !== v.opq) begin
            bad++;
            $display("FAIL %s opcode_q got %h want %h", nm, opcode_q, v.opq);
        end
    endtask

    task automatic cyc(input logic r, input logic [3:0] op, input logic ia, input logic da,
                       input logic az, input logic [2:0] st, input logic [14:0] o,
                       input logic [3:0] q, input string nm);
        apply({r, op, ia, da, az, st, o, q}, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        add(1, 4'h0, 0, 0, 0, RST, A10, 4'h0);
        add(1, 4'h3, 1, 0, 0, FET, IREQ | IRL | A10, 4'h0);
        add(1, 4'h0, 0, 0, 0, DEC, PCW | A10, 4'h3);
        add(1, 4'h0, 0, 0, 0, EXE, 15'h0, 4'h3);
        add(1, 4'h0, 0, 0, 0, WB, RW | A10, 4'h3);
        add(1, 4'h8, 1, 0, 0, FET, IREQ | IRL | A10, 4'h3);
        add(1, 4'h0, 0, 0, 0, DEC, PCW | A10, 4'h8);
        add(1, 4'h0, 0, 0, 0, EXE, A10 | ASRC, 4'h8);
        add(1, 4'h0, 0, 0, 0, MEM, DREQ | A10, 4'h8);
        add(1, 4'h0, 0, 0, 0, MEM, DREQ | A10, 4'h8);
        add(1, 4'h0, 0, 0, 0, MEM, DREQ | A10, 4'h8);
        add(1, 4'h0, 0, 1, 0, MEM, DREQ | A10, 4'h8);
        add(1, 4'h0, 0, 0, 0, WB, RW | M2R | A10, 4'h8);
        add(1, 4'h9, 1, 0, 0, FET, IREQ | IRL | A10, 4'h8);
        add(1, 4'h0, 0, 0, 0, DEC, PCW | A10, 4'h9);
        add(1, 4'h0, 0, 0, 0, EXE, A10 | ASRC, 4'h9);
        add(1, 4'h0, 0, 1, 0, MEM, DREQ | DWE | A10, 4'h9);
        add(1, 4'hA, 1, 0, 0, FET, IREQ | IRL | A10, 4'h9);
        add(1, 4'h0, 0, 0, 0, DEC, PCW | A10, 4'hA);
        add(1, 4'h0, 0, 0, 1, EXE, A01 | PCB | PCW, 4'hA);
        add(1, 4'hA, 1, 0, 0, FET, IREQ | IRL | A10, 4'hA);
        add(1, 4'h0, 0, 0, 0, DEC, PCW | A10, 4'hA);
        add(1, 4'h0, 0, 0, 0, EXE, A01 | PCB, 4'hA);
        add(1, 4'hB, 1, 0, 0, FET, IREQ | IRL | A10, 4'hA);
        add(1, 4'h0, 0, 0, 0, DEC, PCW | A10, 4'hB);
        add(1, 4'h0, 0, 0, 1, EXE, A01 | PCB, 4'hB);
        add(1, 4'hB, 1, 0, 0, FET, IREQ | IRL | A10, 4'hB);
        add(1, 4'h0, 0, 0, 0, DEC, PCW | A10, 4'hB);
        add(1, 4'h0, 0, 0, 0, EXE, A01 | PCB | PCW, 4'hB);
        add(1, 4'hC, 1, 0, 0, FET, IREQ | IRL | A10, 4'hB);
        add(1, 4'h0, 0, 0, 0, DEC, PCW | PCJ | A10, 4'hC);
        add(1, 4'h6, 1, 1, 0, FET, IREQ | IRL | A10, 4'hC);
        add(1, 4'h0, 0, 0, 0, DEC, ILL | A10, 4'h6);
        add(1, 4'h0, 0, 1, 0, FET, IREQ | A10, 4'h6);
        add(1, 4'hF, 1, 0, 0, FET, IREQ | IRL | A10, 4'h6);
        add(1, 4'h0, 0, 0, 0, DEC, A10, 4'hF);
        add(1, 4'h3, 1, 1, 0, HLT, HALT | A10, 4'hF);
        add(1, 4'h0, 0, 0, 0, HLT, HALT | A10, 4'hF);
        add(0, 4'h0, 1, 1, 0, HLT, HALT | A10, 4'hF);
        add(1, 4'h0, 0, 0, 0, RST, A10, 4'h0);

        repeat (2) @(posedge clk);
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted while an LD is waiting in MEM.
        cyc(1, 4'h8, 1, 0, 0, FET, IREQ | IRL | A10, 4'h0, "rst_ld_fetch");
        cyc(1, 4'h0, 0, 0, 0, DEC, PCW | A10, 4'h8, "rst_ld_dec");
        cyc(1, 4'h0, 0, 0, 0, EXE, A10 | ASRC, 4'h8, "rst_ld_exec");
        cyc(0, 4'h0, 0, 0, 0, MEM, DREQ | A10, 4'h8, "rst_ld_mem");
        cyc(1, 4'h0, 0, 0, 0, RST, A10, 4'h0, "rst_ld_rst");

        // Instruction ack on the 16th waiting cycle is still accepted.
        for (int i = 0; i < 15; i++) cyc(1, 4'h0, 0, 0, 0, FET, IREQ | A10, 4'h0, "ack16_wait");
        cyc(1, 4'h1, 1, 0, 0, FET, IREQ | IRL | A10, 4'h0, "ack16_accept");
        cyc(1, 4'h0, 0, 0, 0, DEC, PCW | A10, 4'h1, "ack16_dec");
        cyc(1, 4'h0, 0, 0, 0, EXE, 15'h0, 4'h1, "ack16_exec");
        cyc(1, 4'h0, 0, 0, 0, WB, RW | A10, 4'h1, "ack16_wb");

        // No ack at all: ERROR after 16 FETCH cycles, late acks ignored.
        for (int i = 0; i < 16; i++) cyc(1, 4'h0, 0, 0, 0, FET, IREQ | A10, 4'h1, "to_wait");
        cyc(1, 4'h3, 1, 1, 0, ERR, BERR | A10, 4'h1, "to_error");
        cyc(1, 4'h0, 0, 0, 0, ERR, BERR | A10, 4'h1, "to_sticky");
        cyc(0, 4'h0, 0, 0, 0, ERR, BERR | A10, 4'h1, "to_rst_req");
        cyc(1, 4'h0, 0, 0, 0, RST, A10, 4'h0, "to_rst");
        cyc(1, 4'h0, 0, 0, 0, FET, IREQ | A10, 4'h0, "to_refetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
